// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom_axi_ip result path.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    RS_EMPTY  = 2'd0,
    RS_ACTIVE = 2'd1,
    RS_FULL   = 2'd2,
    RS_ERROR  = 2'd3
  } res_state_e;

  localparam logic [1:0]  RES_STROBE_VALID = 2'b01;
  localparam int unsigned DROP_CNT_W       = 8;

endpackage

// File: rtl/custom_axi_ip_result_fifo_if.sv
// Result valid/ready channel from the result FIFO toward the AXI read-data side.
// CUSTOM_AXI_IP_RES_PARITY_EN adds the parity bit and the consumer parity-error return.
interface custom_axi_ip_result_fifo_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] res_data_o;
  logic                  res_valid_o;
  logic                  res_ready_i;
`ifdef CUSTOM_AXI_IP_RES_PARITY_EN
  logic                  res_parity_o;
  logic                  res_parity_err_i;

  modport master (output res_data_o, res_valid_o, res_parity_o,
                  input  res_ready_i, res_parity_err_i);
  modport slave  (input  res_data_o, res_valid_o, res_parity_o,
                  output res_ready_i, res_parity_err_i);
`else
  modport master (output res_data_o, res_valid_o, input res_ready_i);
  modport slave  (input  res_data_o, res_valid_o, output res_ready_i);
`endif

endinterface

// File: rtl/custom_axi_ip_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module custom_axi_ip_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/custom_axi_ip_result_fifo.sv
// FWFT result FIFO behind the custom_axi_ip stage with drop/error/occupancy status.
// Optional macro CUSTOM_AXI_IP_RES_PARITY_EN: per-entry even parity and consumer parity-error input.
module custom_axi_ip_result_fifo
  import custom_axi_ip_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_WIDTH:0]          din_i,
  input  logic [1:0]                   enable_i,
  input  logic                         clear_i,
  custom_axi_ip_result_fifo_if.master  res_if,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DROP_CNT_W-1:0]        drop_cnt_o,
  output logic [1:0]                   state_o,
  output logic                         err_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;
`ifdef CUSTOM_AXI_IP_RES_PARITY_EN
  localparam int unsigned MEM_W   = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W   = DATA_WIDTH;
`endif

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  res_state_e            state_q, state_d;
  logic                  fifo_full, fifo_empty;
  logic                  push_req, malformed, pop, do_push, drop, par_err, fault;
  logic [MEM_W-1:0]      wr_word, rd_word;

  assign fifo_full  = (level_q == LEVEL_W'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push_req   = (enable_i == RES_STROBE_VALID) && din_i[0];
  assign malformed  = ((enable_i == RES_STROBE_VALID) && !din_i[0]) || enable_i[1];
  assign pop        = !fifo_empty && res_if.res_ready_i;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

`ifdef CUSTOM_AXI_IP_RES_PARITY_EN
  assign par_err = pop && res_if.res_parity_err_i;
  assign wr_word = {^din_i[DATA_WIDTH:1], din_i[DATA_WIDTH:1]};
  assign res_if.res_parity_o = rd_word[DATA_WIDTH];
`else
  assign par_err = 1'b0;
  assign wr_word = din_i[DATA_WIDTH:1];
`endif

  assign fault   = drop || malformed || par_err;
  assign level_d = level_q + LEVEL_W'(do_push) - LEVEL_W'(pop);

  // Next state from post-push/pop level; ERROR is sticky until clear.
  always_comb begin
    state_d = state_q;
    if (clear_i)                               state_d = RS_EMPTY;
    else if (fault || state_q == RS_ERROR)     state_d = RS_ERROR;
    else if (level_d == LEVEL_W'(DEPTH))       state_d = RS_FULL;
    else if (level_d == '0)                    state_d = RS_EMPTY;
    else                                       state_d = RS_ACTIVE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RS_EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  custom_axi_ip_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (do_push && !clear_i),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  assign res_if.res_data_o  = rd_word[DATA_WIDTH-1:0];
  assign res_if.res_valid_o = !fifo_empty;
  assign level_o    = level_q;
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign drop_cnt_o = drop_cnt_q;
  assign state_o    = state_q;
  assign err_o      = (state_q == RS_ERROR);

endmodule

// File: tb/tb_custom_axi_ip_result_fifo.sv
// Scoreboard bench for custom_axi_ip_result_fifo: queue-based reference model, directed plus random stimulus.
module tb_custom_axi_ip_result_fifo;
  import custom_axi_ip_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW:0]   din;
  logic [1:0]    en;
  logic          clr;
  logic [2:0]    level;
  logic          full, empty, err;
  logic [7:0]    drop;
  logic [1:0]    state;

  custom_axi_ip_result_fifo_if #(.DATA_WIDTH(DW)) res_if ();

  custom_axi_ip_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .din_i      (din),
    .enable_i   (en),
    .clear_i    (clr),
    .res_if     (res_if),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .drop_cnt_o (drop),
    .state_o    (state),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of stored payloads, drop count, sticky error.
  logic [15:0] exp_q [$];
  int          m_drop = 0;
  bit          m_err  = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (m_err)                   return 2'(RS_ERROR);
    if (exp_q.size() == 0)       return 2'(RS_EMPTY);
    if (exp_q.size() == DEPTH)   return 2'(RS_FULL);
    return 2'(RS_ACTIVE);
  endfunction

  // Monitor: compares DUT status and head against the model; consumes on handshake.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("valid", 32'(res_if.res_valid_o), 32'(exp_q.size() != 0));
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("full",  32'(full),  32'(exp_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("drop",  32'(drop),  32'(m_drop));
      chk("err",   32'(err),   32'(m_err));
      chk("state", 32'(state), 32'(exp_state()));
      if (exp_q.size() != 0) begin
        chk("data", 32'(res_if.res_data_o), 32'(exp_q[0]));
`ifdef CUSTOM_AXI_IP_RES_PARITY_EN
        chk("parity", 32'(res_if.res_parity_o), 32'(^exp_q[0]));
`endif
        if (res_if.res_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1 with the model updated.
  task automatic step(input logic [1:0] en_v, input logic [15:0] pay, input logic done,
                      input logic rdy, input logic clr_v);
    int sz;
    bit push_req, malf, acc;
    en  = en_v;
    din = {pay, done};
    res_if.res_ready_i = rdy;
    clr = clr_v;
    sz       = exp_q.size();
    push_req = (en_v == 2'b01) && done;
    malf     = ((en_v == 2'b01) && !done) || en_v[1];
    acc      = push_req && ((sz < DEPTH) || (rdy && sz > 0));
    @(posedge clk);
    #1;
    if (clr_v) begin
      exp_q.delete();
      m_drop = 0;
      m_err  = 1'b0;
    end else begin
      if (acc) exp_q.push_back(pay);
      if (push_req && !acc) begin
        if (m_drop < 255) m_drop++;
        m_err = 1'b1;
      end
      if (malf) m_err = 1'b1;
    end
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(res_if.res_valid_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_drop"},  32'(drop),  32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
    chk({tag, "_state"}, 32'(state), 32'(RS_EMPTY));
    chk({tag, "_data"},  32'(res_if.res_data_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    en    = 2'b00;
    clr   = 1'b0;
    res_if.res_ready_i = 1'b0;
`ifdef CUSTOM_AXI_IP_RES_PARITY_EN
    res_if.res_parity_err_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single result
    step(2'b01, 16'hABCD, 1'b1, 1'b0, 1'b0);
    chk("single_valid", 32'(res_if.res_valid_o), 32'd1);
    chk("single_data",  32'(res_if.res_data_o), 32'hABCD);
    chk("single_level", 32'(level), 32'd1);
    idle(1'b1);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_state", 32'(state), 32'(RS_EMPTY));

    // Fill and drain in order
    for (int i = 1; i <= DEPTH; i++) step(2'b01, 16'(i), 1'b1, 1'b0, 1'b0);
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_state", 32'(state), 32'(RS_FULL));
    repeat (DEPTH) idle(1'b1);
    chk("drain_empty", 32'(empty), 32'd1);

    // Overflow and drop counter saturation
    for (int i = 1; i <= DEPTH; i++) step(2'b01, 16'(i), 1'b1, 1'b0, 1'b0);
    step(2'b01, 16'h0005, 1'b1, 1'b0, 1'b0);
    chk("ovf_drop",  32'(drop),  32'd1);
    chk("ovf_err",   32'(err),   32'd1);
    chk("ovf_state", 32'(state), 32'(RS_ERROR));
    chk("ovf_head",  32'(res_if.res_data_o), 32'h0001);
    repeat (300) step(2'b01, 16'($urandom), 1'b1, 1'b0, 1'b0);
    chk("ovf_sat", 32'(drop), 32'd255);

    // Simultaneous push/pop at full
    step(2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) step(2'b01, 16'(16'h10 + i), 1'b1, 1'b0, 1'b0);
    step(2'b01, 16'h0009, 1'b1, 1'b1, 1'b0);
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_drop",  32'(drop),  32'd0);
    chk("pp_err",   32'(err),   32'd0);
    repeat (DEPTH) idle(1'b1);

    // Malformed strobes, then clear alongside a push
    step(2'b01, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(2'b11, 16'h2222, 1'b1, 1'b0, 1'b0);
    chk("malf_empty", 32'(empty), 32'd1);
    chk("malf_err",   32'(err),   32'd1);
    step(2'b01, 16'h0007, 1'b1, 1'b0, 1'b1);
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_err",   32'(err),   32'd0);
    chk("clr_drop",  32'(drop),  32'd0);

    // Asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++) step(2'b01, 16'(16'h30 + i), 1'b1, 1'b0, 1'b0);
    en = 2'b00;
    din = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("areset");
    exp_q.delete();
    m_drop = 0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b01, 16'hABCD, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data",  32'(res_if.res_data_o), 32'hABCD);
    chk("post_rst_level", 32'(level), 32'd1);
    idle(1'b1);

    // Randomized traffic against the model
    repeat (1500) begin
      int r;
      logic [1:0] e;
      logic d;
      r = int'($urandom_range(0, 99));
      if (r < 55)      begin e = 2'b01; d = 1'b1; end
      else if (r < 60) begin e = 2'b01; d = 1'b0; end
      else if (r < 63) begin e = 2'(2 + $urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
      else             begin e = 2'b00; d = 1'($urandom_range(0, 1)); end
      step(e, 16'($urandom), d, 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3));
    end
    repeat (DEPTH + 1) idle(1'b1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
